// File: rtl/square_wave_generator.sv
// square_wave_generator: programmable square-wave source with double-buffered config and burst/continuous modes
module square_wave_generator #(
  parameter int WIDTH = 32,
  parameter int CNT_WIDTH = 16,
  parameter int unsigned DEFAULT_HIGH = 25,
  parameter int unsigned DEFAULT_LOW = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [WIDTH-1:0]     cfg_high_time,
  input  logic [WIDTH-1:0]     cfg_low_time,
  input  logic [CNT_WIDTH-1:0] cfg_count,
  input  logic                 start,
  input  logic                 stop,
  output logic                 signal_out,
  output logic                 busy,
  output logic                 period_done,
  output logic                 burst_done,
  output logic                 cfg_err
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;
  logic [1:0]           state, state_n;
  logic [WIDTH-1:0]     cnt, cnt_n;
  logic [CNT_WIDTH-1:0] periods_left, periods_n;
  logic                 stop_req, stop_req_n;
  logic [WIDTH-1:0]     act_high, act_high_n, act_low, act_low_n;
  logic [CNT_WIDTH-1:0] act_count, act_count_n;
  logic [WIDTH-1:0]     pend_high, pend_high_n, pend_low, pend_low_n;
  logic [CNT_WIDTH-1:0] pend_count, pend_count_n;
  logic                 pending, pending_n;
  logic                 cfg_accept, cfg_bad, cfg_good, period_end, last_period;
  assign cfg_ready   = ~pending;
  assign cfg_accept  = cfg_valid & ~pending;
  assign cfg_bad     = (cfg_high_time == '0) | (cfg_low_time == '0);
  assign cfg_good    = cfg_accept & ~cfg_bad;
  assign period_end  = (state == LOW) && (cnt == '0);
  assign last_period = stop_req | stop | ((act_count != '0) && (periods_left == CNT_WIDTH'(1)));
  assign period_done = period_end;
  assign burst_done  = period_end & last_period;
  assign busy        = state != IDLE;
  // next-state: config buffering, phase counting and period-boundary decisions
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    periods_n    = periods_left;
    stop_req_n   = stop_req;
    act_high_n   = act_high;
    act_low_n    = act_low;
    act_count_n  = act_count;
    pend_high_n  = pend_high;
    pend_low_n   = pend_low;
    pend_count_n = pend_count;
    pending_n    = pending;
    if (cfg_good) begin
      if (state == IDLE || (period_end && last_period)) begin
        act_high_n  = cfg_high_time;
        act_low_n   = cfg_low_time;
        act_count_n = cfg_count;
      end else begin
        pend_high_n  = cfg_high_time;
        pend_low_n   = cfg_low_time;
        pend_count_n = cfg_count;
        pending_n    = 1'b1;
      end
    end
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_n    = HIGH;
          cnt_n      = act_high - 1'b1;
          periods_n  = act_count;
          stop_req_n = 1'b0;
        end
      end
      HIGH: begin
        stop_req_n = stop_req | stop;
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          state_n = LOW;
          cnt_n   = act_low - 1'b1;
        end
      end
      LOW: begin
        if (cnt != '0) begin
          cnt_n      = cnt - 1'b1;
          stop_req_n = stop_req | stop;
        end else begin
          periods_n = (act_count != '0) ? periods_left - 1'b1 : periods_left;
          if (pending) begin
            act_high_n  = pend_high;
            act_low_n   = pend_low;
            act_count_n = pend_count;
            pending_n   = 1'b0;
          end
          if (last_period) begin
            state_n    = IDLE;
            stop_req_n = 1'b0;
          end else begin
            state_n   = HIGH;
            cnt_n     = (pending ? pend_high : act_high) - 1'b1;
            periods_n = pending ? pend_count : periods_n;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
  // state, counters and output register; signal_out follows the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      periods_left <= '0;
      stop_req     <= 1'b0;
      signal_out   <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      periods_left <= periods_n;
      stop_req     <= stop_req_n;
      signal_out   <= state_n == HIGH;
      cfg_err      <= cfg_accept & cfg_bad;
    end
  end
  // active and pending configuration registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_high   <= WIDTH'(DEFAULT_HIGH);
      act_low    <= WIDTH'(DEFAULT_LOW);
      act_count  <= '0;
      pend_high  <= '0;
      pend_low   <= '0;
      pend_count <= '0;
      pending    <= 1'b0;
    end else begin
      act_high   <= act_high_n;
      act_low    <= act_low_n;
      act_count  <= act_count_n;
      pend_high  <= pend_high_n;
      pend_low   <= pend_low_n;
      pend_count <= pend_count_n;
      pending    <= pending_n;
    end
  end
endmodule

// File: tb/tb_square_wave_generator.sv
// tb_square_wave_generator: randomized and directed checks against a period-schedule reference model
module tb_square_wave_generator;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_high_time = '0;
  logic [31:0] cfg_low_time = '0;
  logic [15:0] cfg_count = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        signal_out, busy, period_done, burst_done, cfg_err;
  int checks = 0;
  int errors = 0;
  int mh = 25, ml = 25, mc = 0;
  square_wave_generator dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_high_time(cfg_high_time), .cfg_low_time(cfg_low_time), .cfg_count(cfg_count),
    .start(start), .stop(stop), .signal_out(signal_out), .busy(busy),
    .period_done(period_done), .burst_done(burst_done), .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_cfg(input int h, input int l, input int c);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_high_time = 32'(h);
    cfg_low_time = 32'(l);
    cfg_count = 16'(c);
    #1 check("cfg_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
    #1 check("cfg_err", 32'(cfg_err), 32'((h == 0) || (l == 0)));
    @(negedge clk);
    #1 check("cfg_err_pulse", 32'(cfg_err), 32'd0);
    if (h != 0 && l != 0) begin
      mh = h;
      ml = l;
      mc = c;
    end
  endtask
  // Builds the expected burst as a list of whole periods, then drives start and
  // compares {signal_out, period_done, burst_done, busy, cfg_ready} every cycle.
  task automatic run(input int stop_at, input int cfg_at, input int h2, input int l2, input int c2);
    logic [4:0] expq[$];
    int ch, cl, cc, rem, t, sw_end, tot;
    bit applied, last;
    ch = mh; cl = ml; cc = mc; rem = mc; t = 0; applied = 0; sw_end = -1;
    for (int n = 0; n < 1000; n++) begin
      int p;
      p = ch + cl;
      last = (stop_at >= t && stop_at <= t + p - 1) || (cc != 0 && rem == 1);
      for (int k = 0; k < p; k++)
        expq.push_back({k < ch, k == p - 1, last && (k == p - 1), 1'b1, 1'b0});
      t += p;
      if (last) break;
      if (cfg_at >= 0 && !applied && cfg_at <= t - 2) begin
        applied = 1; sw_end = t - 1; ch = h2; cl = l2; cc = c2; rem = c2;
      end else if (cc != 0) rem--;
    end
    tot = t;
    if (cfg_at >= 0 && !applied) sw_end = tot - 1;
    expq.push_back(5'b0);
    expq.push_back(5'b0);
    foreach (expq[k]) expq[k][0] = !(cfg_at >= 0 && k > cfg_at && k <= sw_end);
    @(negedge clk);
    start = 1'b1;
    stop = 1'b0;
    for (int k = 0; k < tot + 2; k++) begin
      @(negedge clk);
      start = (k < tot) ? 1'($urandom_range(0, 1)) : 1'b0;
      stop = (k == stop_at);
      cfg_valid = (k == cfg_at);
      cfg_high_time = 32'(h2);
      cfg_low_time = 32'(l2);
      cfg_count = 16'(c2);
      #1 check("cycle", 32'({signal_out, period_done, burst_done, busy, cfg_ready}), 32'(expq[k]));
    end
    start = 1'b0;
    stop = 1'b0;
    cfg_valid = 1'b0;
    if (cfg_at >= 0) begin
      mh = h2; ml = l2; mc = c2;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int h, l, c, p, cfg_at, stop_at, h2, l2, c2;
    #1;
    check("rst_outs", 32'({signal_out, busy, period_done, burst_done, cfg_err}), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run(149, -1, 1, 1, 0);
    do_cfg(3, 5, 4);
    run(-1, -1, 1, 1, 0);
    do_cfg(10, 10, 0);
    run(40, 4, 2, 6, 0);
    do_cfg(10, 10, 0);
    run(4, -1, 1, 1, 0);
    do_cfg(0, 7, 2);
    run(0, -1, 1, 1, 0);
    @(negedge clk);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 check("start_stop_idle", 32'({signal_out, busy}), 32'd0);
      @(negedge clk);
    end
    do_cfg(17, 33, 2);
    run(-1, -1, 1, 1, 0);
    for (int i = 0; i < 10; i++) begin
      h = $urandom_range(1, 6);
      l = $urandom_range(1, 6);
      c = $urandom_range(0, 3);
      do_cfg(h, l, c);
      p = h + l;
      cfg_at = $urandom_range(0, 1) ? int'($urandom_range(0, p - 1)) : -1;
      h2 = $urandom_range(1, 6);
      l2 = $urandom_range(1, 6);
      c2 = $urandom_range(0, 3);
      stop_at = (c == 0 || (cfg_at >= 0 && c2 == 0) || $urandom_range(0, 1) == 1)
                ? int'($urandom_range(0, 4 * p)) : -1;
      run(stop_at, cfg_at, h2, l2, c2);
    end
    do_cfg(4, 6, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    cfg_valid = 1'b1;
    cfg_high_time = 32'd9;
    cfg_low_time = 32'd9;
    cfg_count = 16'd1;
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1 check("pre_rst_low", 32'({signal_out, busy, cfg_ready}), 32'b010);
    #1 rst = 1'b0;
    #1 check("async_rst_outs", 32'({signal_out, busy, period_done, burst_done, cfg_err}), 32'd0);
    check("async_rst_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    mh = 25; ml = 25; mc = 0;
    run(0, -1, 1, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/square_wave_generator.md
# square_wave_generator

- Programmable square-wave source: the transmit-side counterpart of the input-capture path.
- Drives `signal_out` high for exactly `high_time` clock cycles and low for exactly `low_time` cycles, repeating for a programmed number of periods or continuously.
- Used as an on-chip stimulus for the frequency-measurement chain. Values captured by the capture block must equal the programmed `high_time`/`low_time`.
- New configurations are double-buffered and applied only at period boundaries, so the output never glitches.

## Interface
- `WIDTH`, 32, width of high/low time fields (clock cycles)
- `CNT_WIDTH`, 16, width of burst period count
- `DEFAULT_HIGH`, 25, high time loaded at reset
- `DEFAULT_LOW`, 25, low time loaded at reset (1 MHz at 50 MHz clk)

Ports:
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  reset, asynchronous, active-low
- `cfg_valid`  in  1  configuration offered
- `cfg_ready`  out  1  configuration can be accepted; transfer when both high
- `cfg_high_time`  in  WIDTH  high-phase length in cycles
- `cfg_low_time`  in  WIDTH  low-phase length in cycles
- `cfg_count`  in  CNT_WIDTH  periods per burst; 0 = continuous
- `start`  in  1  begin output (level sampled each cycle)
- `stop`  in  1  request stop at end of current period
- `signal_out`  out  1  generated waveform (registered)
- `busy`  out  1  high in HIGH/LOW states
- `period_done`  out  1  1-cycle pulse on last cycle of each period
- `burst_done`  out  1  1-cycle pulse when returning to IDLE
- `cfg_err`  out  1  1-cycle pulse: accepted config rejected (high or low = 0)

## Operation
- Registers:
  - active config: high, low, count. Reset value is `DEFAULT_HIGH`/`DEFAULT_LOW`/0.
  - pending config plus `pending` flag.
  - down-counter `cnt` (WIDTH).
  - `periods_left` (CNT_WIDTH).
  - `stop_req` flag.
- FSM states: IDLE, HIGH, LOW.
- Configuration handshake:
  - `cfg_ready = ~pending`.
  - In IDLE, an accepted config is written straight to the active registers on the next edge; `pending` stays 0.
  - In HIGH/LOW, an accepted config is written to pending and `pending` is set. `cfg_ready` stays low until the config is applied.
  - If `cfg_high_time == 0` or `cfg_low_time == 0`, the config is accepted but discarded: `cfg_err` pulses and the active/pending registers are unchanged.
- IDLE: when `start=1` and `stop=0`, go to HIGH.
  - `cnt <= high-1`, `periods_left <= count`, `stop_req <= 0`.
  - If `stop` and `start` are both high, `stop` wins and the FSM stays in IDLE.
- HIGH:
  - When `cnt != 0`, decrement it.
  - When `cnt == 0`, go to LOW with `cnt <= low-1`.
- LOW, when `cnt != 0`: decrement it.
- LOW, when `cnt == 0` (period end): pulse `period_done`; if `count != 0`, decrement `periods_left`.
  - If `stop_req`, or `stop` this cycle, or (`count != 0` and `periods_left == 1`): go to IDLE and pulse `burst_done`.
  - Otherwise: if `pending`, copy pending to active and clear `pending` (the new high/low/count take effect from this HIGH; `periods_left` reloads with the new count). Then go to HIGH with `cnt <= high-1` of the now-active config.
- `stop` in HIGH/LOW sets `stop_req`. The current period always completes; the output is never truncated.
- `start` while busy is ignored.
- A pending config left at burst end is applied on entry to IDLE.
- `signal_out` = 1 exactly in HIGH, 0 otherwise. It is registered from the next-state value, so it changes on the same edge as the state.

## Timing
- Reset (async assert, `rst=0`):
  - state IDLE; `signal_out`, `busy`, `period_done`, `burst_done`, `cfg_err` = 0.
  - `cfg_ready` = 1; `pending` = 0; `cnt` = 0.
- `start` sampled at edge t: `signal_out` and `busy` rise at edge t.
- Per period: `signal_out` is high for exactly `high` cycles, then low for exactly `low` cycles. Period = `high + low` cycles, with no gap cycles between periods.
- Period-end pulses: `period_done` is high during the final LOW cycle. `burst_done` pulses in that same cycle, and `busy` falls at the following edge.
- Maximum phase is 2^WIDTH − 1 cycles. The counter never wraps because loads are always ≥ 0 after the −1.
- A config applied in IDLE at edge t is used by a `start` sampled at edge t+1 or later. A `start` in the same cycle as `cfg_valid` uses the old config.
- Reset mid-period forces `signal_out` low immediately (async) and discards pending config and `stop_req`.

## Test plan
- Reset, then `start` with defaults: `signal_out` alternates 25 high / 25 low continuously; `period_done` pulses every 50 cycles.
- Config high=3, low=5, count=4, then `start`: exactly 4 periods of 3H/5L, 4 `period_done` pulses, 1 `burst_done` on cycle 32, `busy` low afterwards.
- Continuous run high=10, low=10; config high=2, low=6 offered mid-HIGH: `cfg_ready` drops, the current 10/10 period completes, the next period is 2H/6L, and `cfg_ready` returns high.
- `stop` asserted 4 cycles into HIGH of a 10/10 run: that period finishes in full (10H/10L), `burst_done` pulses, `signal_out` stays low.
- Config high=0, low=7: `cfg_err` pulses for one cycle and the active config is unchanged (the next start still produces the previous waveform). `start` and `stop` together in IDLE: no output.
- Loopback into the capture block with high=17, low=33: captured high_time/low_time match the capture block's counting convention for 17/33. Async reset mid-LOW: all outputs return to reset values immediately.
